// File: rtl/pe_tilde_inv_if.sv
// Beat-level bus for the inverse tilde PE: modulus, input pair with valid/ready,
// output pair with valid/ready.
interface pe_tilde_inv_if #(
   parameter int W = 8
);
   logic [W-1:0] q;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] data_top_i;
   logic [W-1:0] data_bot_i;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] intt_top_o;
   logic [W-1:0] intt_bot_o;

   modport master (
      output q, in_valid, data_top_i, data_bot_i, out_ready,
      input  in_ready, out_valid, intt_top_o, intt_bot_o
   );

   modport slave (
      input  q, in_valid, data_top_i, data_bot_i, out_ready,
      output in_ready, out_valid, intt_top_o, intt_bot_o
   );
endinterface

// File: rtl/pe_tilde_inv.sv
// Inverse tilde butterfly: (x, y) -> ((x+y)/2, (x-y)/2) mod q.
// Stage 1 does the modular add/sub, stage 2 the modular halving.
module pe_tilde_inv #(
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           reset,
   pe_tilde_inv_if.slave  bus
);

   logic         s1_v, s2_v;
   logic         adv1, adv2;
   logic [W-1:0] s1_sum, s1_dif;
   logic [W-1:0] s2_top, s2_bot;
   logic [W-1:0] sum_n, dif_n;
   logic [W:0]   s_w, s_q, d_w;

   // Odd v is made even by adding q; the extra bit keeps the carry for q near 2^W.
   function automatic logic [W-1:0] half(input logic [W-1:0] v, input logic [W-1:0] m);
      logic [W:0] t;
      t = v[0] ? ({1'b0, v} + {1'b0, m}) : {1'b0, v};
      return t[W:1];
   endfunction

   assign adv2         = !s2_v || bus.out_ready;
   assign adv1         = !s1_v || adv2;
   assign bus.in_ready = adv1;

   always_comb begin
      s_w   = {1'b0, bus.data_top_i} + {1'b0, bus.data_bot_i};
      s_q   = s_w - {1'b0, bus.q};
      sum_n = (s_w >= {1'b0, bus.q}) ? s_q[W-1:0] : s_w[W-1:0];
      d_w   = {1'b0, bus.data_top_i} - {1'b0, bus.data_bot_i};
      // Borrow out of the W+1-bit difference means x < y; wrap by q.
      dif_n = d_w[W] ? (d_w[W-1:0] + bus.q) : d_w[W-1:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_v   <= 1'b0;
         s1_sum <= '0;
         s1_dif <= '0;
      end else if (adv1) begin
         s1_v   <= bus.in_valid;
         s1_sum <= sum_n;
         s1_dif <= dif_n;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s2_v   <= 1'b0;
         s2_top <= '0;
         s2_bot <= '0;
      end else if (adv2) begin
         s2_v   <= s1_v;
         s2_top <= half(s1_sum, bus.q);
         s2_bot <= half(s1_dif, bus.q);
      end
   end

   assign bus.out_valid  = s2_v;
   assign bus.intt_top_o = s2_top;
   assign bus.intt_bot_o = s2_bot;

endmodule

// File: tb/tb_pe_tilde_inv.sv
// Directed vectors, random streaming with backpressure, and async reset
// with beats in flight for pe_tilde_inv (W=8).
module tb_pe_tilde_inv;

   localparam int W = 8;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic [W-1:0] top;
      logic [W-1:0] bot;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   applied = 0;
   int   miscompares = 0;
   logic [2*W-1:0] exp_q[$];

   pe_tilde_inv_if #(.W(W)) bus ();

   pe_tilde_inv #(.W(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      applied++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // One isolated beat: accepted on the first edge, visible after the second.
   task automatic apply_vec(input vec_t v, input int idx);
      @(negedge clk);
      bus.q = v.q; bus.data_top_i = v.x; bus.data_bot_i = v.y;
      bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      #1 chk($sformatf("v%0d_in_ready", idx), int'(bus.in_ready), 1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1 chk($sformatf("v%0d_early_valid", idx), int'(bus.out_valid), 0);
      @(negedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", idx), int'(bus.out_valid), 1);
      chk($sformatf("v%0d_top", idx), int'(bus.intt_top_o), int'(v.top));
      chk($sformatf("v%0d_bot", idx), int'(bus.intt_bot_o), int'(v.bot));
   endtask

   // Forward tilde model generates (x,y) from random (a,b); the block must return (a,b).
   task automatic run_stream(input int n, input int rdy_pct, input int vld_pct,
                             input logic [W-1:0] qq);
      int sent, got, cnt, a, b;
      logic stall, acc, cons;
      logic [W-1:0] ht, hb;
      logic [2*W-1:0] pend, e;
      sent = 0; got = 0; cnt = 0; stall = 1'b0; ht = '0; hb = '0; pend = '0;
      bus.q = qq;
      for (int cyc = 0; cyc < n * 20 + 50; cyc++) begin
         @(negedge clk);
         if (stall) begin
            chk("stall_valid", int'(bus.out_valid), 1);
            chk("stall_top", int'(bus.intt_top_o), int'(ht));
            chk("stall_bot", int'(bus.intt_bot_o), int'(hb));
         end
         bus.out_ready = ($urandom_range(99, 0) < rdy_pct);
         if (sent < n && $urandom_range(99, 0) < vld_pct) begin
            a = $urandom_range(int'(qq) - 1, 0);
            b = $urandom_range(int'(qq) - 1, 0);
            bus.data_top_i = W'((a + b) % int'(qq));
            bus.data_bot_i = W'((a - b + int'(qq)) % int'(qq));
            pend = {W'(a), W'(b)};
            bus.in_valid = 1'b1;
         end else begin
            bus.in_valid = 1'b0;
         end
         #1;
         chk("in_ready", int'(bus.in_ready), int'(!(cnt == 2 && !bus.out_ready)));
         acc  = bus.in_valid && bus.in_ready;
         cons = bus.out_valid && bus.out_ready;
         if (cons) begin
            if (exp_q.size() == 0) begin
               chk("spurious_out", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("stream_top", int'(bus.intt_top_o), int'(e[2*W-1:W]));
               chk("stream_bot", int'(bus.intt_bot_o), int'(e[W-1:0]));
            end
            got++;
         end
         if (acc) begin
            exp_q.push_back(pend);
            sent++;
         end
         stall = bus.out_valid && !bus.out_ready;
         ht = bus.intt_top_o;
         hb = bus.intt_bot_o;
         cnt = cnt + int'(acc) - int'(cons);
         if (got >= n) break;
      end
      bus.in_valid = 1'b0;
      chk("stream_count", got, n);
      exp_q.delete();
   endtask

   initial begin
      vec_t vecs[10];
      vecs[0] = '{q:8'd17,  x:8'd3,   y:8'd5,   top:8'd4,   bot:8'd16};
      vecs[1] = '{q:8'd251, x:8'd250, y:8'd250, top:8'd250, bot:8'd0};
      vecs[2] = '{q:8'd17,  x:8'd1,   y:8'd0,   top:8'd9,   bot:8'd9};
      vecs[3] = '{q:8'd255, x:8'd254, y:8'd254, top:8'd254, bot:8'd0};
      vecs[4] = '{q:8'd255, x:8'd254, y:8'd0,   top:8'd127, bot:8'd127};
      vecs[5] = '{q:8'd17,  x:8'd0,   y:8'd16,  top:8'd8,   bot:8'd9};
      vecs[6] = '{q:8'd3,   x:8'd2,   y:8'd1,   top:8'd0,   bot:8'd2};
      vecs[7] = '{q:8'd251, x:8'd0,   y:8'd250, top:8'd125, bot:8'd126};
      vecs[8] = '{q:8'd17,  x:8'd16,  y:8'd15,  top:8'd7,   bot:8'd9};
      vecs[9] = '{q:8'd255, x:8'd1,   y:8'd254, top:8'd0,   bot:8'd1};

      bus.q = 8'd17; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      bus.data_top_i = '0; bus.data_bot_i = '0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_top", int'(bus.intt_top_o), 0);
      chk("rst_bot", int'(bus.intt_bot_o), 0);
      @(negedge clk);
      reset = 1'b0;
      #1 chk("rst_in_ready", int'(bus.in_ready), 1);

      for (int i = 0; i < 10; i++) apply_vec(vecs[i], i);

      run_stream(1000, 100, 100, 8'd251);
      run_stream(300, 30, 60, 8'd255);
      run_stream(200, 30, 90, 8'd17);

      // Fill both stages under backpressure, then reset mid-cycle.
      @(negedge clk);
      bus.q = 8'd17; bus.data_top_i = 8'd3; bus.data_bot_i = 8'd5;
      bus.in_valid = 1'b1; bus.out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      chk("full_out_valid", int'(bus.out_valid), 1);
      chk("full_top", int'(bus.intt_top_o), 4);
      chk("full_in_ready", int'(bus.in_ready), 0);
      #2 reset = 1'b1;
      #1;
      chk("async_out_valid", int'(bus.out_valid), 0);
      chk("async_top", int'(bus.intt_top_o), 0);
      chk("async_bot", int'(bus.intt_bot_o), 0);
      @(negedge clk);
      reset = 1'b0;
      #1 chk("post_rst_in_ready", int'(bus.in_ready), 1);
      apply_vec('{q:8'd17, x:8'd0, y:8'd0, top:8'd0, bot:8'd0}, 99);

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
